// File: rtl/hc595_ctrl_if.sv
// Parallel pattern / 74HC595 pin bundle for hc595_ctrl.
// HC595_DIM_EN adds the dim_duty brightness input.
interface hc595_ctrl_if;
  logic [5:0] sel;
  logic [7:0] seg;
`ifdef HC595_DIM_EN
  logic [7:0] dim_duty;
`endif
  logic       ds;
  logic       shcp;
  logic       stcp;
  logic       oe;
  logic       frame_done;

`ifdef HC595_DIM_EN
  modport master (output sel, seg, dim_duty, input ds, shcp, stcp, oe, frame_done);
  modport slave  (input sel, seg, dim_duty, output ds, shcp, stcp, oe, frame_done);
`else
  modport master (output sel, seg, input ds, shcp, stcp, oe, frame_done);
  modport slave  (input sel, seg, output ds, shcp, stcp, oe, frame_done);
`endif
endinterface

// File: rtl/hc595_ctrl.sv
// Serial driver for two cascaded 74HC595s: snapshots {seg,sel}, shifts it
// MSB first on ds/shcp, latches with stcp, and repeats back to back.
// Optional macro HC595_DIM_EN adds PWM brightness control on oe.
module hc595_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  hc595_ctrl_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [3:0]       BIT_LAST = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [3:0]       bit_cnt, bit_nxt;
  logic [13:0]      shreg, shreg_nxt;
  logic             ds_q, ds_nxt;
  logic             shcp_q, shcp_nxt;
  logic             stcp_q, stcp_nxt;
  logic             oe_q, oe_nxt;
  logic             done_q, done_nxt;
  logic             latched, latched_nxt;
  logic [13:0]      word;
  logic             div_end;

  assign word    = {bus.seg, bus.sel};
  assign div_end = (div_cnt == DIV_LAST);

`ifdef HC595_DIM_EN
  logic [7:0] pwm_cnt;

  // Free-running brightness counter, wraps 255->0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pwm_cnt <= '0;
    else            pwm_cnt <= pwm_cnt + 8'd1;
  end
`endif

  // Next-state and next-output logic for the shift/latch sequencer.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    bit_nxt     = bit_cnt;
    shreg_nxt   = shreg;
    ds_nxt      = ds_q;
    shcp_nxt    = 1'b0;
    stcp_nxt    = 1'b0;
    done_nxt    = 1'b0;
    latched_nxt = latched;

    unique case (state)
      IDLE: begin
        state_nxt = SHIFT;
        shreg_nxt = word;
        div_nxt   = '0;
        bit_nxt   = '0;
        ds_nxt    = 1'b0;
      end

      SHIFT: begin
        ds_nxt   = shreg[BIT_LAST - bit_cnt];
        shcp_nxt = (div_cnt >= DIV_HALF);
        if (div_end) begin
          div_nxt = '0;
          if (bit_cnt == BIT_LAST) state_nxt = LATCH;
          else                     bit_nxt   = bit_cnt + 4'd1;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      LATCH: begin
        stcp_nxt = (div_cnt >= DIV_HALF);
        if (div_end) begin
          done_nxt    = 1'b1;
          latched_nxt = 1'b1;
          state_nxt   = SHIFT;
          shreg_nxt   = word;
          div_nxt     = '0;
          bit_nxt     = '0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

`ifdef HC595_DIM_EN
    oe_nxt = latched_nxt ? ~(pwm_cnt < bus.dim_duty) : 1'b1;
`else
    oe_nxt = ~latched_nxt;
`endif
  end

  // State and registered-output update; reset forces display-safe values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ds_q    <= 1'b0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      oe_q    <= 1'b1;
      done_q  <= 1'b0;
      latched <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      ds_q    <= ds_nxt;
      shcp_q  <= shcp_nxt;
      stcp_q  <= stcp_nxt;
      oe_q    <= oe_nxt;
      done_q  <= done_nxt;
      latched <= latched_nxt;
    end
  end

  assign bus.ds         = ds_q;
  assign bus.shcp       = shcp_q;
  assign bus.stcp       = stcp_q;
  assign bus.oe         = oe_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_hc595_ctrl.sv
// Scoreboard bench for hc595_ctrl: a frame-level model pushes the expected
// serial bits at each 60-cycle frame boundary; a monitor checks the pins.
module tb_hc595_ctrl;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 15 * CLK_DIV;
  localparam int NBITS   = 14;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 sys_clk = ~sys_clk;

  hc595_ctrl_if bus();

  hc595_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = -1;
  logic exp_q[$];
`ifdef HC595_DIM_EN
  int   duty_seen = 0;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a new word is captured every FRAME cycles after reset release.
  initial begin
    logic [13:0] w;
    forever begin
      @(posedge sys_clk);
      if (!sys_rst_n) begin
        cyc = -1;
        exp_q.delete();
      end else begin
        cyc++;
        if (cyc % FRAME == 0) begin
          w = {bus.seg, bus.sel};
          for (int i = NBITS - 1; i >= 0; i--) exp_q.push_back(w[i]);
        end
      end
`ifdef HC595_DIM_EN
      duty_seen = int'(bus.dim_duty);
`endif
    end
  end

  // Monitor: samples pins on the falling edge.
  initial begin
    logic prev_shcp, prev_stcp, e;
    int   shcp_run, stcp_run, rises, oe_exp;
    prev_shcp = 0; prev_stcp = 0; shcp_run = 0; stcp_run = 0; rises = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        check("rst_ds", int'(bus.ds), 0);
        check("rst_shcp", int'(bus.shcp), 0);
        check("rst_stcp", int'(bus.stcp), 0);
        check("rst_oe", int'(bus.oe), 1);
        check("rst_frame_done", int'(bus.frame_done), 0);
        prev_shcp = 0; prev_stcp = 0; shcp_run = 0; stcp_run = 0; rises = 0;
      end else begin
        if (bus.shcp && !prev_shcp) begin
          if (exp_q.size() == 0) begin
            check("unexpected_shcp_rise", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("ds_bit", int'(bus.ds), int'(e));
          end
          rises++;
        end
        if (bus.shcp) shcp_run++;
        else begin
          if (prev_shcp) check("shcp_high_width", shcp_run, CLK_DIV / 2);
          shcp_run = 0;
        end

        if (bus.stcp) check("stcp_while_shcp_low", int'(bus.shcp), 0);
        if (bus.stcp && !prev_stcp) begin
          check("shcp_rises_per_latch", rises, NBITS);
          rises = 0;
        end
        if (bus.stcp) stcp_run++;
        else begin
          if (prev_stcp) check("stcp_high_width", stcp_run, CLK_DIV / 2);
          stcp_run = 0;
        end

        check("frame_done", int'(bus.frame_done), int'(cyc > 0 && cyc % FRAME == 0));
`ifdef HC595_DIM_EN
        oe_exp = (cyc >= FRAME) ? int'(!((cyc % 256) < duty_seen)) : 1;
`else
        oe_exp = (cyc >= FRAME) ? 0 : 1;
`endif
        check("oe", int'(bus.oe), oe_exp);

        prev_shcp = bus.shcp;
        prev_stcp = bus.stcp;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Stimulus: directed frames, random pattern churn, then a mid-frame reset.
  initial begin
    int waited;
    bus.sel = 6'h3F;
    bus.seg = 8'hC0;
`ifdef HC595_DIM_EN
    bus.dim_duty = 8'd64;
`endif
    cycles(5);
    sys_rst_n = 1'b1;

    // Change seg while bit 5 of the first frame is on the wire.
    cycles(22);
    bus.seg = 8'hF9;
    cycles(2 * FRAME);

    // Random pattern updates at random times over ten frames.
    for (int i = 0; i < 10 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.sel = 6'($urandom);
        bus.seg = 8'($urandom);
      end
      cycles(1);
    end

    // Reset during bit 7, hold for three cycles.
    waited = 0;
    while (cyc % FRAME != 1 + 7 * CLK_DIV + 1 && waited < 2 * FRAME) begin
      cycles(1);
      waited++;
    end
    check("reach_bit7_within_budget", int'(waited < 2 * FRAME), 1);
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_stcp", int'(bus.stcp), 0);
    check("async_rst_shcp", int'(bus.shcp), 0);
    check("async_rst_oe", int'(bus.oe), 1);
    cycles(3);
    sys_rst_n = 1'b1;

`ifdef HC595_DIM_EN
    cycles(3 * FRAME);
    bus.dim_duty = 8'd0;
    cycles(2 * 256);
`else
    cycles(4 * FRAME);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
